// File: rtl/fetch_pkg.sv
// fetch_pkg: opcodes, state encoding and reset constants
// shared by the instruction fetch front end.
package fetch_pkg;

    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_NOP  = 5'b00001;

    localparam logic [15:0] RESET_INSTR = {OP_NOP, 11'd0};

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    function automatic logic is_halt(input logic [15:0] instr);
        return instr[15:11] == OP_HALT;
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with synchronous reset,
// redirect load and +2 increment (16-bit modulo, always even).
module fetch_pc_reg #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [15:0] i_load_pc,
    input  logic        i_inc,
    output logic [15:0] pc,
    output logic [15:0] pc_plus2
);

    logic [15:0] r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= {i_load_pc[15:1], 1'b0};
        end else if (i_inc) begin
            r_pc <= pc_plus2;
        end
    end

    assign pc       = r_pc;
    assign pc_plus2 = r_pc + 16'd2;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC ownership, single-outstanding imem requests,
// decode handoff with stall, redirect squash and HALT stop.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_valid,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_instr,
    output logic [15:0] if_pc_plus2,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        halted
);

    fetch_state_e r_state;
    logic         r_req;
    logic         r_squash;
    logic [15:0]  r_instr;
    logic [15:0]  r_pc_plus2;

    logic [15:0]  w_pc;
    logic [15:0]  w_pc_plus2;
    logic         w_take;

    // a response is kept only when unsquashed and not overridden
    assign w_take = !redirect && (r_state == ST_WAIT)
                  && imem_valid && !r_squash;

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst       (rst),
        .i_load    (redirect),
        .i_load_pc (redirect_pc),
        .i_inc     (w_take),
        .pc        (w_pc),
        .pc_plus2  (w_pc_plus2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_FETCH;
            r_req      <= 1'b0;
            r_squash   <= 1'b0;
            r_instr    <= RESET_INSTR;
            r_pc_plus2 <= 16'h0000;
        end else if (redirect) begin
            r_state  <= ST_FETCH;
            r_req    <= 1'b1;
            r_squash <= 1'b0;
            // a request is in flight: wait it out and drop it
            if ((r_state == ST_FETCH && r_req) ||
                (r_state == ST_WAIT && !imem_valid)) begin
                r_state  <= ST_WAIT;
                r_req    <= 1'b0;
                r_squash <= 1'b1;
            end
        end else begin
            r_req <= 1'b0;
            unique case (r_state)
                ST_FETCH: begin
                    if (r_req) r_state <= ST_WAIT;
                    else       r_req   <= 1'b1;
                end
                ST_WAIT: begin
                    if (imem_valid && r_squash) begin
                        r_squash <= 1'b0;
                        r_state  <= ST_FETCH;
                        r_req    <= 1'b1;
                    end else if (imem_valid) begin
                        r_instr    <= imem_rdata;
                        r_pc_plus2 <= w_pc_plus2;
                        r_state    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (!id_stall && is_halt(r_instr)) begin
                        r_state <= ST_HALTED;
                    end else if (!id_stall) begin
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end
                end
                ST_HALTED: ;
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = w_pc;
    assign if_valid    = (r_state == ST_HOLD);
    assign if_instr    = r_instr;
    assign if_pc_plus2 = r_pc_plus2;
    assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a
// variable-latency memory model and hand-computed expectations.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        imem_req, imem_valid, if_valid;
    logic        id_stall, redirect, halted;
    logic [15:0] imem_addr, imem_rdata, if_instr;
    logic [15:0] if_pc_plus2, redirect_pc;

    logic        z_req, z_valid, z_if_valid, z_halted;
    logic [15:0] z_addr, z_instr, z_pc2;
    logic        z_pend = 1'b0;
    logic        z_stall = 1'b0;
    logic        z_redir = 1'b0;
    logic [15:0] z_redir_pc = 16'h0000;
    logic [15:0] z_rdata = 16'h4000;

    fetch_unit u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc_plus2 (if_pc_plus2),
        .id_stall    (id_stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) u_wrap (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (z_req),
        .imem_addr   (z_addr),
        .imem_valid  (z_valid),
        .imem_rdata  (z_rdata),
        .if_valid    (z_if_valid),
        .if_instr    (z_instr),
        .if_pc_plus2 (z_pc2),
        .id_stall    (z_stall),
        .redirect    (z_redir),
        .redirect_pc (z_redir_pc),
        .halted      (z_halted)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [15:0] mem [256];
    int          lat = 1;
    int          pend = 0;
    logic [15:0] pend_addr = 16'h0000;
    int          req_n = 0;
    int          req_cyc [64];
    logic [15:0] req_adr [64];

    initial begin
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        z_valid    = 1'b0;
    end

    // memory models: inputs change only on the falling edge
    always @(negedge clk) begin
        imem_valid = 1'b0;
        imem_rdata = 16'hDEAD;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                imem_valid = 1'b1;
                imem_rdata = mem[pend_addr[8:1]];
            end
        end
        if (imem_req) begin
            pend      = lat;
            pend_addr = imem_addr;
            if (req_n < 64) begin
                req_cyc[req_n] = cyc;
                req_adr[req_n] = imem_addr;
            end
            req_n++;
        end
        z_valid = z_pend;
        z_pend  = z_req;
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!if_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({tag, " if_valid"}, 32'(if_valid), 32'd1);
    endtask

    int  saved;
    logic seen;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h4000 + 16'(i);
        mem[3] = 16'h0000;
        rst = 1'b1;
        id_stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst if_valid", 32'(if_valid), 32'd0);
        chk("rst if_instr", 32'(if_instr), 32'h0800);
        chk("rst pc2", 32'(if_pc_plus2), 32'd0);
        chk("rst halted", 32'(halted), 32'd0);
        chk("rst req", 32'(imem_req), 32'd0);
        chk("rst addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;

        wait_valid("w0");
        chk("w0 instr", 32'(if_instr), 32'h4000);
        chk("w0 pc2", 32'(if_pc_plus2), 32'h0002);
        chk("wrap pc2", 32'(z_pc2), 32'h0000);
        chk("wrap instr", 32'(z_instr), 32'h4000);
        @(negedge clk);
        chk("w0 next req", 32'(imem_req), 32'd1);
        chk("w0 next addr", 32'(imem_addr), 32'h0002);
        chk("wrap next req", 32'(z_req), 32'd1);
        chk("wrap next addr", 32'(z_addr), 32'h0000);

        wait_valid("w1");
        chk("w1 instr", 32'(if_instr), 32'h4001);
        chk("w1 pc2", 32'(if_pc_plus2), 32'h0004);
        id_stall = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall valid", 32'(if_valid), 32'd1);
            chk("stall instr", 32'(if_instr), 32'h4001);
            chk("stall req", 32'(imem_req), 32'd0);
        end
        id_stall = 1'b0;
        @(negedge clk);
        chk("accept req", 32'(imem_req), 32'd1);
        chk("accept addr", 32'(imem_addr), 32'h0004);

        @(negedge clk);
        wait_valid("w2");
        chk("w2 instr", 32'(if_instr), 32'h4002);
        chk("w2 pc2", 32'(if_pc_plus2), 32'h0006);

        @(negedge clk);
        wait_valid("w3");
        chk("w3 instr", 32'(if_instr), 32'h0000);
        chk("w3 pc2", 32'(if_pc_plus2), 32'h0008);
        @(negedge clk);
        chk("halt halted", 32'(halted), 32'd1);
        chk("halt valid", 32'(if_valid), 32'd0);
        saved = req_n;
        repeat (5) @(negedge clk);
        chk("halt no req", 32'(req_n), 32'(saved));
        chk("halt stays", 32'(halted), 32'd1);

        chk("req0 addr", 32'(req_adr[0]), 32'h0000);
        chk("req1 addr", 32'(req_adr[1]), 32'h0002);
        chk("req2 addr", 32'(req_adr[2]), 32'h0004);
        chk("req3 addr", 32'(req_adr[3]), 32'h0006);
        chk("req gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
        chk("req gap23", 32'(req_cyc[3] - req_cyc[2]), 32'd3);

        redirect = 1'b1;
        redirect_pc = 16'h0020;
        @(negedge clk);
        redirect = 1'b0;
        chk("unhalt halted", 32'(halted), 32'd0);
        chk("unhalt req", 32'(imem_req), 32'd1);
        chk("unhalt addr", 32'(imem_addr), 32'h0020);
        @(negedge clk);
        wait_valid("w4");
        chk("w4 instr", 32'(if_instr), 32'h4010);
        chk("w4 pc2", 32'(if_pc_plus2), 32'h0022);

        lat = 3;
        redirect = 1'b1;
        redirect_pc = 16'h0010;
        @(negedge clk);
        redirect = 1'b0;
        chk("hold redir valid", 32'(if_valid), 32'd0);
        chk("hold redir req", 32'(imem_req), 32'd1);
        chk("hold redir addr", 32'(imem_addr), 32'h0010);
        @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0101;
        @(negedge clk);
        redirect = 1'b0;
        chk("wait redir req", 32'(imem_req), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 20 && !imem_req; k++) begin
            seen |= if_valid;
            @(negedge clk);
        end
        seen |= if_valid;
        chk("squash no valid", 32'(seen), 32'd0);
        chk("squash req", 32'(imem_req), 32'd1);
        chk("squash addr", 32'(imem_addr), 32'h0100);
        @(negedge clk);
        wait_valid("w5");
        chk("w5 instr", 32'(if_instr), 32'h4080);
        chk("w5 pc2", 32'(if_pc_plus2), 32'h0102);

        lat = 2;
        @(negedge clk);
        chk("coll req", 32'(imem_req), 32'd1);
        chk("coll addr", 32'(imem_addr), 32'h0102);
        repeat (2) @(negedge clk);
        redirect = 1'b1;
        redirect_pc = 16'h0040;
        @(negedge clk);
        redirect = 1'b0;
        chk("coll valid", 32'(if_valid), 32'd0);
        chk("coll new req", 32'(imem_req), 32'd1);
        chk("coll new addr", 32'(imem_addr), 32'h0040);
        @(negedge clk);
        wait_valid("w6");
        chk("w6 instr", 32'(if_instr), 32'h4020);
        chk("w6 pc2", 32'(if_pc_plus2), 32'h0042);

        rst = 1'b1;
        @(negedge clk);
        chk("hold rst valid", 32'(if_valid), 32'd0);
        chk("hold rst instr", 32'(if_instr), 32'h0800);
        chk("hold rst req", 32'(imem_req), 32'd0);
        chk("hold rst pc2", 32'(if_pc_plus2), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 10 && !imem_req; k++) @(negedge clk);
        chk("post rst req", 32'(imem_req), 32'd1);
        chk("post rst addr", 32'(imem_addr), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end that produces the 16-bit instruction stream consumed by `instruction_decoder`. It owns the PC, issues one-at-a-time requests to a variable-latency instruction memory, and presents each fetched word with its PC+2 to decode under a valid/stall handshake. It also applies branch/jump redirects from execute and stops fetching after delivering a HALT (opcode 5'b00000).

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `imem_req`  out  1: one-cycle request pulse to instruction memory.
- `imem_addr`  out  16: fetch address; equals the PC, held stable until the response arrives.
- `imem_valid`  in  1: response strobe; arrives at least 1 cycle after `imem_req`.
- `imem_rdata`  in  16: instruction word; sampled only when `imem_valid`=1.
- `if_valid`  out  1: `if_instr` and `if_pc_plus2` are valid for decode.
- `if_instr`  out  16: fetched instruction; bits [15:11] drive the decoder opcode input.
- `if_pc_plus2`  out  16: address of the fetched instruction + 2, used for JAL/JALR link and branch targets.
- `id_stall`  in  1: decode cannot accept; hold the current word.
- `redirect`  in  1: taken branch/jump; overrides all other activity except `rst`.
- `redirect_pc`  in  16: new PC; bit 0 is forced to 0.
- `halted`  out  1: a HALT has been accepted by decode; fetching has stopped.

## Operation
- States: FETCH, WAIT, HOLD, HALTED. Each state has a 1-bit `squash` flag, which is only meaningful in WAIT.
- FETCH: `imem_req`=1 with `imem_addr`=PC. Next state is WAIT.
- WAIT: on `imem_valid` with `squash`=0, latch `imem_rdata` into `if_instr`, set `if_pc_plus2`=PC+2, set PC to PC+2, and go to HOLD. On `imem_valid` with `squash`=1, discard the response, clear `squash`, and go to FETCH.
- HOLD: `if_valid`=1. While `id_stall`=1, hold every output unchanged. When `id_stall`=0 (accept):
  - if `if_instr[15:11]`=5'b00000, go to HALTED;
  - otherwise, go to FETCH.
- HALTED: `imem_req`=0, `if_valid`=0, `halted`=1. Only `redirect` or `rst` leaves this state. A redirect here means the HALT was on the wrong path.
- Redirect handling, with the PC set to `redirect_pc` in every case:
  - In FETCH, the request is still issued. Go to WAIT with `squash`=1.
  - In WAIT without `imem_valid`, set `squash`=1 and stay in WAIT.
  - In WAIT with `imem_valid` in the same cycle, discard the response and go to FETCH.
  - In HOLD, drop `if_valid` next cycle and go to FETCH. This applies even if `id_stall`=0; no accept occurs.
  - In HALTED, clear `halted` and go to FETCH.
- PC arithmetic is 16-bit modulo: 16'hFFFE + 2 = 16'h0000. The PC is always even.
- At most one memory request is outstanding. `imem_req` never asserts while in WAIT.

## Timing
- Reset values:
  - state = FETCH, PC = `RESET_PC`;
  - `imem_req`=0, `imem_addr`=`RESET_PC`, `squash`=0;
  - `if_valid`=0, `if_instr`=16'h0800 (NOP), `if_pc_plus2`=0, `halted`=0.
- First `imem_req` is issued in the first cycle after `rst` deasserts.
- All outputs are registered; none depend combinationally on any input.
- Minimum latency with `imem_valid` 1 cycle after the request:
  - cycle 0: request;
  - cycle 1: response;
  - cycle 2: `if_valid`;
  - cycle 3: next request, if the word was accepted in cycle 2.
- Maximum throughput is 1 instruction per 3 cycles.
- `rst` asserted mid-transaction abandons any outstanding request. A late `imem_valid` arriving in the first FETCH after reset is ignored, because responses are sampled only in WAIT.
- `redirect` takes effect on the same edge on which it is sampled.

## Structure
- Shared package `fetch_pkg` holds:
  - opcode constants `OP_HALT`=5'b00000 and `OP_NOP`=5'b00001 (the same values as in `opcodes.v`);
  - the state enum (2-bit);
  - the reset instruction constant 16'h0800.
- One sub-module, `fetch_pc_reg`: the PC register with synchronous reset, load (redirect), and +2 increment enable. It exposes `pc` and `pc_plus2`.
- The state machine and the instruction/PC+2 output registers live in `fetch_unit`.

## Test plan
- Reset then free-run: memory at 1-cycle latency returns 16'h4000, 16'h4001, 16'h4002 at addresses 0, 2, 4, with `id_stall`=0.
  - Required: requests at 0, 2, 4 spaced 3 cycles apart.
  - Required: `if_pc_plus2` = 2, 4, 6.
- Decode stall: hold `id_stall`=1 for 4 cycles while in HOLD.
  - Required: `if_instr` and `if_valid` are stable for those cycles.
  - Required: no `imem_req` until the first cycle after accept.
- Redirect in WAIT: memory latency 3; assert `redirect` with `redirect_pc`=16'h0101 one cycle after the request to 16'h0010.
  - Required: that response is discarded and `if_valid` stays 0.
  - Required: the next request goes to 16'h0100.
- Halt: the word at 16'h0006 is 16'h0000.
  - Required: after accept, `halted`=1 and no further `imem_req`.
  - Required: a later `redirect` to 16'h0020 clears `halted` and issues a request to 16'h0020.
- Wrap and collision:
  - With `RESET_PC`=16'hFFFE, the first `if_pc_plus2`=16'h0000 and the next request is to 16'h0000.
  - `redirect` in the same cycle as `imem_valid` in WAIT discards that response.
- Reset in HOLD: asserting `rst` while `if_valid`=1 gives `if_valid`=0 and `if_instr`=16'h0800 next cycle, and the first request after reset goes to `RESET_PC`.
